// File: rtl/cic_interp_if.sv
// Stream/handshake bundle for cic_interp.
// The sticky clip flag 'sat' exists only when CIC_INTERP_SAT_EN is defined.
interface cic_interp_if #(
    parameter int BITS = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic signed [BITS-1:0] x_in;
    logic                   out_tick;
    logic signed [15:0]     x_out;
    logic                   out_valid;
    logic                   underrun;
`ifdef CIC_INTERP_SAT_EN
    logic                   sat;
`endif

    modport master (
        output in_valid, output x_in, output out_tick,
        input  in_ready, input  x_out, input  out_valid, input underrun
`ifdef CIC_INTERP_SAT_EN
        , input sat
`endif
    );

    modport slave (
        input  in_valid, input  x_in, input  out_tick,
        output in_ready, output x_out, output out_valid, output underrun
`ifdef CIC_INTERP_SAT_EN
        , output sat
`endif
    );
endinterface

// File: rtl/cic_interp.sv
// CIC interpolator: low-rate comb section, zero-stuff by INTERP, high-rate integrators paced by out_tick.
// Optional feature macro CIC_INTERP_SAT_EN: saturate x_out to 16-bit signed range and raise sticky 'sat'.
module cic_interp #(
    parameter int BITS      = 8,
    parameter int INTERP    = 8,
    parameter int STAGES    = 3,
    parameter int WIDTH     = 17,
    parameter int OUT_SHIFT = 0
) (
    input  logic       CLK,
    input  logic       RST,
    cic_interp_if.slave bus
);
    localparam int PW = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(INTERP - 1);

    typedef logic signed [WIDTH-1:0] acc_t;

    logic               full_q, full_d;
    acc_t               held_q, held_d;
    logic [PW-1:0]      phase_q, phase_d;
    acc_t               delay_q [STAGES];
    acc_t               delay_d [STAGES];
    acc_t               integ_q [STAGES];
    acc_t               integ_d [STAGES];
    logic signed [15:0] xOut_q, xOut_d;
    logic               outValid_q, outValid_d;
    logic               consume;
    acc_t               combTap [STAGES];
    acc_t               combOut;
`ifdef CIC_INTERP_SAT_EN
    localparam acc_t SAT_MAX = acc_t'(32767);
    localparam acc_t SAT_MIN = acc_t'(-32768);
    logic               sat_q, sat_d;
    acc_t               shifted;

    assign shifted = integ_q[STAGES-1] >>> OUT_SHIFT;
    assign bus.sat = sat_q;
`endif

    assign consume       = bus.out_tick && (phase_q == '0);
    assign bus.in_ready  = !full_q;
    assign bus.underrun  = consume && !full_q && !RST;
    assign bus.x_out     = xOut_q;
    assign bus.out_valid = outValid_q;

    // Comb chain: a starved consume feeds zero, which keeps the decay well defined.
    always_comb begin
        acc_t c;
        c = full_q ? held_q : '0;
        for (int k = 0; k < STAGES; k++) begin
            combTap[k] = c;
            c = c - delay_q[k];
        end
        combOut = c;
    end

    always_comb begin
        full_d     = full_q;
        held_d     = held_q;
        phase_d    = phase_q;
        delay_d    = delay_q;
        integ_d    = integ_q;
        xOut_d     = xOut_q;
        outValid_d = 1'b0;
`ifdef CIC_INTERP_SAT_EN
        sat_d      = sat_q;
`endif
        if (bus.out_tick) begin
            phase_d    = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
            integ_d[0] = integ_q[0] + (consume ? combOut : '0);
            for (int k = 1; k < STAGES; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            outValid_d = 1'b1;
`ifdef CIC_INTERP_SAT_EN
            if (shifted > SAT_MAX) begin
                xOut_d = 16'sh7fff;
                sat_d  = 1'b1;
            end else if (shifted < SAT_MIN) begin
                xOut_d = 16'sh8000;
                sat_d  = 1'b1;
            end else begin
                xOut_d = shifted[15:0];
            end
`else
            xOut_d = 16'(integ_q[STAGES-1] >>> OUT_SHIFT);
`endif
        end
        // Consume is applied before capture so a starved consume never swallows a same-cycle capture.
        if (consume) begin
            full_d = 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                delay_d[k] = combTap[k];
            end
        end
        if (bus.in_valid && !full_q) begin
            full_d = 1'b1;
            held_d = {{(WIDTH-BITS){bus.x_in[BITS-1]}}, bus.x_in};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            full_q     <= 1'b0;
            held_q     <= '0;
            phase_q    <= '0;
            xOut_q     <= '0;
            outValid_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                delay_q[k] <= '0;
                integ_q[k] <= '0;
            end
`ifdef CIC_INTERP_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            full_q     <= full_d;
            held_q     <= held_d;
            phase_q    <= phase_d;
            xOut_q     <= xOut_d;
            outValid_q <= outValid_d;
            delay_q    <= delay_d;
            integ_q    <= integ_d;
`ifdef CIC_INTERP_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end
endmodule
